// File: rtl/bch_correct_buffer.sv
// bch_correct_buffer: receive-side correction buffer for the BCH decode path.
// Loads a serial codeword (MSB-first), keeps the leading DATA_BITS as the data
// word, applies the Chien-search error-locator stream as a flip mask, then
// holds the corrected word behind a valid/ack handshake.
module bch_correct_buffer #(
   parameter int DATA_BITS = 4,
   parameter int CODE_BITS = 15,
   parameter int BITS      = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             code_valid,
   input  logic [BITS-1:0]                  code_in,
   output logic                             code_ready,
   input  logic                             err_first,
   input  logic                             err_valid,
   input  logic [BITS-1:0]                  err,
   output logic [DATA_BITS-1:0]             data_out,
   output logic [$clog2(DATA_BITS+1)-1:0]   err_count,
   output logic                             data_valid,
   input  logic                             data_ack,
   output logic                             protocol_err
);

   localparam int CODE_BEATS = CODE_BITS / BITS;
   localparam int DATA_BEATS = DATA_BITS / BITS;
   localparam int CBW        = $clog2(CODE_BEATS + 1);
   localparam int EBW        = $clog2(DATA_BEATS + 1);
   localparam int CNTW       = $clog2(DATA_BITS + 1);

   localparam logic [CBW-1:0] CODE_LAST = CBW'(CODE_BEATS - 1);
   localparam logic [CBW-1:0] DATA_END  = CBW'(DATA_BEATS);
   localparam logic [EBW-1:0] ERR_LAST  = EBW'(DATA_BEATS - 1);

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_CORRECT = 2'd1,
      S_OUT     = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CBW-1:0]       code_cnt;
   logic [EBW-1:0]       err_idx;
   logic [DATA_BITS-1:0] data_reg;
   logic [DATA_BITS-1:0] mask;
   logic [CNTW-1:0]      err_cnt_q;
   logic                 prot_q;

   logic                 code_acc;
   logic                 err_beat;
   logic                 err_acc;
   logic                 last_code;
   logic                 last_err;
   logic [EBW-1:0]       err_pos;
   logic [DATA_BITS-1:0] err_ext;
   logic [DATA_BITS-1:0] mask_nxt;
   logic [CNTW-1:0]      beat_pop;
   logic [CNTW-1:0]      cnt_nxt;

   assign code_acc  = (state == S_LOAD) && code_valid;
   assign err_beat  = err_first || err_valid;
   assign err_acc   = (state == S_CORRECT) && err_beat;
   assign last_code = code_acc && (code_cnt == CODE_LAST);
   // err_first restarts the pass, so its beat always lands at index 0
   assign err_pos   = err_first ? '0 : err_idx;
   assign last_err  = err_acc && (err_pos == ERR_LAST);

   // Place the error beat at its data bit position and fold it into the mask
   always_comb begin
      err_ext = '0;
      err_ext[BITS-1:0] = err;
      mask_nxt = (err_first ? '0 : mask) ^ (err_ext << (int'(err_pos) * BITS));
   end

   // Number of flips carried by the current error beat, added to the running count
   always_comb begin
      beat_pop = '0;
      for (int unsigned i = 0; i < BITS; i++) begin
         beat_pop = beat_pop + CNTW'(err[i]);
      end
      cnt_nxt = (err_first ? '0 : err_cnt_q) + beat_pop;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_LOAD;
      else     state <= state_nxt;
   end

   // Next-state logic: load codeword, collect error beats, hold result until ack
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_LOAD:    if (last_code) state_nxt = S_CORRECT;
         S_CORRECT: if (last_err)  state_nxt = S_OUT;
         S_OUT:     if (data_ack)  state_nxt = S_LOAD;
         default:   state_nxt = S_LOAD;
      endcase
   end

   // Datapath: codeword capture, mask/count accumulation, sticky protocol flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_cnt  <= '0;
         err_idx   <= '0;
         data_reg  <= '0;
         mask      <= '0;
         err_cnt_q <= '0;
         prot_q    <= 1'b0;
      end else begin
         if (code_acc) begin
            code_cnt <= last_code ? '0 : code_cnt + CBW'(1);
            // only the leading data beats are kept; ECC beats are dropped
            if (code_cnt < DATA_END) data_reg <= DATA_BITS'({data_reg, code_in});
         end
         if (last_code) begin
            mask      <= '0;
            err_idx   <= '0;
            err_cnt_q <= '0;
         end
         if (err_acc) begin
            mask      <= mask_nxt;
            err_cnt_q <= cnt_nxt;
            err_idx   <= err_pos + EBW'(1);
         end
         if (err_beat && (state != S_CORRECT)) prot_q <= 1'b1;
      end
   end

   assign code_ready   = (state == S_LOAD);
   assign data_valid   = (state == S_OUT);
   assign data_out     = (state == S_OUT) ? (data_reg ^ mask) : '0;
   assign err_count    = err_cnt_q;
   assign protocol_err = prot_q;

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Testbench for bch_correct_buffer: directed scenarios plus randomized passes
// on a BITS=1 (15-bit codeword) instance and a BITS=2 (16-bit codeword) instance.
module tb_bch_correct_buffer;

   logic clk = 1'b0;
   logic rst;

   logic       a_code_valid, a_code_ready, a_err_first, a_err_valid;
   logic       a_data_valid, a_data_ack, a_protocol_err;
   logic [0:0] a_code_in, a_err;
   logic [3:0] a_data_out;
   logic [2:0] a_err_count;

   logic       b_code_valid, b_code_ready, b_err_first, b_err_valid;
   logic       b_data_valid, b_data_ack, b_protocol_err;
   logic [1:0] b_code_in, b_err;
   logic [3:0] b_data_out;
   logic [2:0] b_err_count;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   bch_correct_buffer #(.DATA_BITS(4), .CODE_BITS(15), .BITS(1)) dut_a (
      .clk(clk), .rst(rst),
      .code_valid(a_code_valid), .code_in(a_code_in), .code_ready(a_code_ready),
      .err_first(a_err_first), .err_valid(a_err_valid), .err(a_err),
      .data_out(a_data_out), .err_count(a_err_count), .data_valid(a_data_valid),
      .data_ack(a_data_ack), .protocol_err(a_protocol_err)
   );

   bch_correct_buffer #(.DATA_BITS(4), .CODE_BITS(16), .BITS(2)) dut_b (
      .clk(clk), .rst(rst),
      .code_valid(b_code_valid), .code_in(b_code_in), .code_ready(b_code_ready),
      .err_first(b_err_first), .err_valid(b_err_valid), .err(b_err),
      .data_out(b_data_out), .err_count(b_err_count), .data_valid(b_data_valid),
      .data_ack(b_data_ack), .protocol_err(b_protocol_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: received data is the leading 4 serial bits; error vector bit k flips data bit k
   function automatic logic [3:0] model_data(input logic [3:0] recv, input logic [3:0] ev);
      return recv ^ ev;
   endfunction

   function automatic logic [2:0] model_count(input logic [3:0] ev);
      return 3'($countones(ev));
   endfunction

   // Serialize a 15-bit codeword; optional err_valid / err_first pulses at 1-based beat numbers
   task automatic a_load(input logic [14:0] cw, input int valid_at, input int first_at);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 0) chk("a_ready_load", a_code_ready, 1);
         a_code_valid = 1'b1;
         a_code_in    = cw[14-i];
         a_err_valid  = (i + 1 == valid_at);
         a_err_first  = (i + 1 == first_at);
      end
      @(negedge clk);
      a_code_valid = 1'b0;
      a_err_valid  = 1'b0;
      a_err_first  = 1'b0;
      chk("a_ready_drop", a_code_ready, 0);
   endtask

   task automatic a_errs(input logic [3:0] ev, input logic use_first);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 3) chk("a_valid_early", a_data_valid, 0);
         a_err_first = (k == 0) && use_first;
         a_err_valid = !((k == 0) && use_first);
         a_err       = ev[k];
      end
   endtask

   task automatic a_finish(input int hold, input logic [3:0] exp_d, input logic [2:0] exp_c);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         a_err_first = 1'b0;
         a_err_valid = 1'b0;
         a_err       = 1'b0;
         chk("a_valid", a_data_valid, 1);
         chk("a_data", a_data_out, exp_d);
         chk("a_count", a_err_count, exp_c);
         if (i == hold - 1) a_data_ack = 1'b1;
      end
      @(negedge clk);
      a_data_ack = 1'b0;
      chk("a_valid_drop", a_data_valid, 0);
      chk("a_ready_back", a_code_ready, 1);
   endtask

   task automatic b_load(input logic [15:0] cw);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b_code_valid = 1'b1;
         b_code_in    = cw[15-2*i -: 2];
      end
      @(negedge clk);
      b_code_valid = 1'b0;
      chk("b_ready_drop", b_code_ready, 0);
   endtask

   task automatic b_errs(input logic [3:0] ev, input logic use_first);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (k == 1) chk("b_valid_early", b_data_valid, 0);
         b_err_first = (k == 0) && use_first;
         b_err_valid = !((k == 0) && use_first);
         b_err       = ev[2*k +: 2];
      end
   endtask

   task automatic b_finish(input int hold, input logic [3:0] exp_d, input logic [2:0] exp_c);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         b_err_first = 1'b0;
         b_err_valid = 1'b0;
         b_err       = '0;
         chk("b_valid", b_data_valid, 1);
         chk("b_data", b_data_out, exp_d);
         chk("b_count", b_err_count, exp_c);
         if (i == hold - 1) b_data_ack = 1'b1;
      end
      @(negedge clk);
      b_data_ack = 1'b0;
      chk("b_valid_drop", b_data_valid, 0);
      chk("b_ready_back", b_code_ready, 1);
   endtask

   initial begin
      logic [14:0] cw;
      logic [15:0] cwb;
      logic [3:0]  ev;
      logic        uf;

      rst = 1'b1;
      a_code_valid = 0; a_code_in = 0; a_err_first = 0; a_err_valid = 0; a_err = 0; a_data_ack = 0;
      b_code_valid = 0; b_code_in = 0; b_err_first = 0; b_err_valid = 0; b_err = 0; b_data_ack = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", a_code_ready, 1);
      chk("rst_valid", a_data_valid, 0);
      chk("rst_data", a_data_out, 0);
      chk("rst_count", a_err_count, 0);
      chk("rst_prot", a_protocol_err, 0);
      chk("rst_b_ready", b_code_ready, 1);
      chk("rst_b_valid", b_data_valid, 0);
      rst = 1'b0;

      // Nominal: data 0011, channel error 15'h3000, locator stream 0,1,1,0
      cw = {4'b0011, 11'($urandom)} ^ 15'h3000;
      a_load(cw, 0, 0);
      a_errs(4'b0110, 1'b1);
      a_finish(1, 4'b0011, 3'd2);

      // Clean codeword, held 5 cycles before ack
      cw = {4'b0011, 11'($urandom)};
      a_load(cw, 0, 0);
      a_errs(4'b0000, 1'b1);
      a_finish(5, 4'b0011, 3'd0);

      // Restart: partial pass 1,1 then a fresh pass 0,0,0,1; data_ack in CORRECT is ignored
      cw = {4'b1011, 11'($urandom)};
      a_load(cw, 0, 0);
      @(negedge clk); a_err_first = 1; a_err_valid = 0; a_err = 1; a_data_ack = 1;
      @(negedge clk); a_err_first = 0; a_err_valid = 1; a_err = 1;
      @(negedge clk); a_err_first = 1; a_err_valid = 0; a_err = 0; a_data_ack = 0;
      @(negedge clk); a_err_first = 0; a_err_valid = 1; a_err = 0;
      @(negedge clk); a_err = 0;
      @(negedge clk); a_err = 1;
      chk("restart_valid_early", a_data_valid, 0);
      a_finish(1, 4'b0011, 3'd1);

      // Protocol error: err_valid during load beat 7
      chk("prot_before", a_protocol_err, 0);
      cw = 15'($urandom);
      ev = 4'($urandom) | 4'b0001;
      a_load(cw, 7, 0);
      chk("prot_set", a_protocol_err, 1);
      a_errs(ev, 1'b1);
      a_finish(1, model_data(cw[14:11], ev), model_count(ev));
      chk("prot_sticky", a_protocol_err, 1);

      // Reset after 9 beats of a new codeword
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         a_code_valid = 1'b1;
         a_code_in    = 1'($urandom);
      end
      @(negedge clk);
      a_code_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_ready", a_code_ready, 1);
      chk("midrst_valid", a_data_valid, 0);
      chk("midrst_data", a_data_out, 0);
      chk("midrst_count", a_err_count, 0);
      chk("midrst_prot", a_protocol_err, 0);
      @(negedge clk);
      rst = 1'b0;
      cw = 15'($urandom);
      ev = 4'($urandom);
      a_load(cw, 0, 0);
      a_errs(ev, 1'b1);
      a_finish(1, model_data(cw[14:11], ev), model_count(ev));
      chk("midrst_prot_after", a_protocol_err, 0);

      // err_first on the final code beat is ignored; pass then starts with err_valid
      cw = 15'($urandom);
      ev = 4'($urandom);
      a_load(cw, 0, 15);
      chk("final_beat_prot", a_protocol_err, 1);
      a_errs(ev, 1'b0);
      a_finish(1, model_data(cw[14:11], ev), model_count(ev));

      // Randomized passes, BITS=1
      for (int n = 0; n < 12; n++) begin
         cw = 15'($urandom);
         ev = 4'($urandom);
         uf = 1'($urandom);
         a_load(cw, 0, 0);
         a_errs(ev, uf);
         a_finish(int'($urandom_range(1, 3)), model_data(cw[14:11], ev), model_count(ev));
      end

      // BITS=2: beats 2'b10, 2'b01 flip data bits 1 and 2
      cwb = {4'b1001, 12'($urandom)};
      b_load(cwb);
      b_errs(4'b0110, 1'b1);
      b_finish(1, 4'b1111, 3'd2);

      for (int n = 0; n < 8; n++) begin
         cwb = 16'($urandom);
         ev  = 4'($urandom);
         uf  = 1'($urandom);
         b_load(cwb);
         b_errs(ev, uf);
         b_finish(int'($urandom_range(1, 3)), model_data(cwb[15:12], ev), model_count(ev));
      end
      chk("b_prot_clean", b_protocol_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/bch_correct_buffer.md
# bch_correct_buffer

Receive-side correction buffer for the BCH path. It takes a serial codeword, keeps its data portion, and applies the serial error-locator stream from the Chien search (`bch_error_tmec` / `bch_chien_counter` outputs). It then presents the corrected data word with a valid/ack handshake. It sits after the syndrome/BMA/Chien chain and is the counterpart of the data serializer that feeds `bch_encode`. It closes the decode loop for PUF helper-data reconstruction.

## Interface
Parameters:
- DATA_BITS, 4, data (message) bits per codeword; multiple of BITS
- CODE_BITS, 15, total codeword bits (data + ECC); multiple of BITS, > DATA_BITS
- BITS, 1, bits per serial beat (codeword input and error stream)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- code_valid  in  1  codeword beat present on code_in
- code_in  in  BITS  codeword beat, MSB-first; bit [BITS-1] is the earlier bit
- code_ready  out  1  block accepts codeword beats
- err_first  in  1  first error beat of a Chien pass (beat carries data)
- err_valid  in  1  subsequent error beat valid
- err  in  BITS  error-locator beat; 1 = flip corresponding data bit
- data_out  out  DATA_BITS  corrected data word
- err_count  out  $clog2(DATA_BITS+1)  number of data bits flipped
- data_valid  out  1  data_out/err_count valid
- data_ack  in  1  consumer takes data_out
- protocol_err  out  1  sticky: error beat arrived outside CORRECT state

## Operation
- States: LOAD (reset state), CORRECT, OUT.
- LOAD: code_ready=1. Each cycle with code_valid, shift code_in into the codeword register and increment the beat counter. After beat CODE_BITS/BITS is accepted, go to CORRECT. Clear mask, err beat counter and err_count on entry.
- Data word = the first DATA_BITS serial bits. The first serial bit is data_out MSB. ECC beats are accepted and discarded.
- CORRECT: a beat is accepted when err_first | err_valid.
  - err_first restarts the pass: clear the mask and set beat index to 0 before applying this beat.
  - Error beat k XORs into data bits [k*BITS +: BITS]. Beat 0 is the data LSBs.
  - err_count accumulates the popcount of each beat.
  - After beat DATA_BITS/BITS-1, go to OUT.
  - err_valid without a prior err_first in this pass is accepted as beat 0.
- OUT: data_valid=1. data_out = stored data ^ mask, held stable. On data_ack, go to LOAD next cycle. data_ack outside OUT is ignored.
- err_first/err_valid in LOAD or OUT: beat ignored, protocol_err set (cleared only by rst).
- Beats beyond DATA_BITS/BITS are impossible: the state exits CORRECT first.
- Counter widths: code beat counter is $clog2(CODE_BITS/BITS+1); err beat counter is $clog2(DATA_BITS/BITS+1). No wrap inside a pass.

## Timing
- Reset (asynchronous): state=LOAD, code_ready=1, data_valid=0, data_out=0, err_count=0, protocol_err=0, all counters and mask 0.
- code_ready is combinational from state only, with no dependence on code_valid.
- Last code beat accepted in cycle n: code_ready=0 from cycle n+1. Error beats are accepted from cycle n+1.
- Last error beat in cycle m: data_valid=1 and corrected data_out in cycle m+1.
- data_ack sampled high in cycle p while data_valid: data_valid=0 and code_ready=1 in cycle p+1.
- Error beat coinciding with the final code beat (LOAD): ignored, protocol_err=1.
- rst asserted mid-pass: immediate return to reset values. The partial codeword is discarded.

## Test plan
- Nominal, DATA_BITS=4, CODE_BITS=15, BITS=1: serialize encoded 4'b0011 with error 15'h3000, then stream err 0,1,1,0 (err_first on beat 0). Required: data_out=4'b0011, err_count=2, data_valid exactly 1 cycle after the 4th error beat.
- No errors: clean codeword, err all zero. Required: data_out=4'b0011, err_count=0. data_valid holds for 5 cycles until data_ack, then code_ready=1 next cycle.
- Restart: err_first, beats 1,1, then err_first again with 0,0,0,1. Required: mask=4'b1000 only, err_count=1.
- Protocol error: err_valid pulsed during LOAD beat 7. Required: protocol_err=1 sticky, codeword load unaffected, result still correct.
- Reset mid-load after 9 beats, then a full new codeword. Required: all outputs return to reset values immediately. The new word decodes correctly with no residue from the old one.
- BITS=2 variant, DATA_BITS=4, CODE_BITS=16: error beats 2'b10, 2'b01 flip data bits 1 and 2. Required: err_count=2, data_valid 1 cycle after the 2nd beat.
